pmp_trap_unit: RTL
==================

PMP_TRAP_UNIT -- requirements
Module: pmp_trap_unit

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 8, giving the width of the violation counter.
REQ-002 The block SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port Instr_Fault  input  1  instruction-fetch PMP check failed this cycle (instr_pmp_ok low).
REQ-005 The block SHALL have port Data_Fault  input  1  data-access PMP check failed this cycle (data_pmp_ok low).
REQ-006 The block SHALL have port Fault_PC  input  8  PC of the faulting instruction.
REQ-007 The block SHALL have port Fault_Addr  input  32  data address (ALU result) of the faulting access.
REQ-008 The block SHALL have port Fault_Opcode  input  7  opcode of the faulting instruction.
REQ-009 The block SHALL have port Trap_Ack  input  1  trap consumer has taken the trap.
REQ-010 The block SHALL have port Log_Clear  input  1  synchronous clear of counter and Missed flag.
REQ-011 The block SHALL have port Trap_Req  output  1  registered trap request.
REQ-012 The block SHALL have port Trap_Cause  output  4  1 = instr access fault, 5 = load access fault, 7 = store access fault.
REQ-013 The block SHALL have port Trap_PC  output  8  captured Fault_PC.
REQ-014 The block SHALL have port Trap_Tval  output  32  captured fault value.
REQ-015 The block SHALL have port Stall  output  1  pipeline hold while a trap is pending.
REQ-016 The block SHALL have port Violation_Count  output  COUNT_W  saturating count of fault cycles.
REQ-017 The block SHALL have port Missed  output  1  sticky: a fault arrived while it could not be captured.

Function
REQ-018 A fault cycle SHALL be any cycle with Instr_Fault or Data_Fault high.
REQ-019 FSM states SHALL be IDLE, TRAP and HOLDOFF, with Trap_Req = (state == TRAP) and Stall = (state != IDLE), both registered.
REQ-020 In IDLE or HOLDOFF, a fault cycle SHALL capture Trap_PC, Trap_Cause and Trap_Tval and enter TRAP on the same edge, so Trap_Req is high one cycle after the fault.
REQ-021 In HOLDOFF without a fault, the FSM SHALL return to IDLE after exactly one cycle.
REQ-022 When Instr_Fault and Data_Fault are both high, instruction fault SHALL win: cause 1, with Trap_Tval = Fault_PC zero-extended.
REQ-023 On a data fault, cause SHALL be 7 if Fault_Opcode == 7'b0100011 (store), otherwise 5, with Trap_Tval = Fault_Addr.
REQ-024 In TRAP, Trap_Ack high SHALL move the FSM to HOLDOFF; otherwise it stays in TRAP with captured fields held stable.
REQ-025 In TRAP, a fault cycle SHALL NOT overwrite the captured fields, SHALL set Missed, and SHALL still increment the counter; this also applies when Trap_Ack is high in the same cycle.
REQ-026 Trap_Ack outside TRAP SHALL be ignored.
REQ-027 Violation_Count SHALL increment by 1 per fault cycle and saturate at 2^COUNT_W-1 without wrap.
REQ-028 Log_Clear SHALL zero Violation_Count and Missed; when Log_Clear coincides with a fault cycle, the count SHALL become 1 and Missed SHALL follow REQ-025.
REQ-029 Log_Clear SHALL NOT affect FSM state or the captured fields.

Reset
REQ-030 Reset_n low SHALL immediately force IDLE and drive Trap_Req, Stall, Missed, Trap_Cause, Trap_PC, Trap_Tval and Violation_Count to 0, including mid-trap.
REQ-031 After Reset_n deasserts, the first rising edge SHALL be treated as a normal cycle.

Structure
REQ-032 Package pmp_trap_pkg SHALL hold the state enum, the cause constants (1, 5, 7) and the STORE opcode constant.
REQ-033 The saturating counter SHALL be sub-module pmp_sat_counter (params WIDTH; ports inc, clr), instantiated once.

Verification
REQ-034 Data_Fault=1, Fault_Opcode=0000011, Fault_Addr=0x0000_1000 for one cycle -> next cycle Trap_Req=1, Cause=5, Tval=0x1000, Stall=1, Count=1.
REQ-035 Both faults, Fault_PC=0x2C, Opcode=0100011 -> Cause=1, Tval=0x0000_002C; hold Trap_Ack=0 10 cycles -> fields stable; Trap_Ack=1 -> HOLDOFF one cycle, then Stall=0.
REQ-036 In TRAP, store fault with Trap_Ack=1 the same cycle -> Missed=1, Count=2, captured fields unchanged, FSM in HOLDOFF.
REQ-037 Fault in HOLDOFF -> TRAP re-entered next cycle with new fields; 300 fault cycles with COUNT_W=8 -> Count=255; Log_Clear with a fault -> Count=1.
REQ-038 Reset_n pulsed low asynchronously mid-TRAP -> all outputs 0 before the next edge; Trap_Ack in IDLE -> no change.

Source files
------------

// File: rtl/pmp_trap_pkg.sv
// Shared types and constants for the PMP access-fault trap unit.
// Holds the trap FSM states, the RISC-V mcause codes and the STORE opcode.
package pmp_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAP    = 2'd1,
    ST_HOLDOFF = 2'd2
  } trap_state_e;

  localparam logic [3:0] CAUSE_INSTR_ACCESS = 4'd1;
  localparam logic [3:0] CAUSE_LOAD_ACCESS  = 4'd5;
  localparam logic [3:0] CAUSE_STORE_ACCESS = 4'd7;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // An instruction fault takes priority over a data fault.
  function automatic logic [3:0] fault_cause(input logic instr_fault,
                                             input logic [6:0] opcode);
    if (instr_fault)
      return CAUSE_INSTR_ACCESS;
    else if (opcode == OPC_STORE)
      return CAUSE_STORE_ACCESS;
    else
      return CAUSE_LOAD_ACCESS;
  endfunction

endpackage

// File: rtl/pmp_sat_counter.sv
// Saturating up-counter with synchronous clear.
// A clear coinciding with an increment leaves the count at one.
module pmp_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pmp_trap_unit.sv
// PMP access-fault trap unit: captures the first fault into trap CSR-style fields,
// holds the pipeline until acknowledged, and logs total and missed faults.
module pmp_trap_unit
  import pmp_trap_pkg::*;
#(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Instr_Fault,
  input  logic               Data_Fault,
  input  logic [7:0]         Fault_PC,
  input  logic [31:0]        Fault_Addr,
  input  logic [6:0]         Fault_Opcode,
  input  logic               Trap_Ack,
  input  logic               Log_Clear,
  output logic               Trap_Req,
  output logic [3:0]         Trap_Cause,
  output logic [7:0]         Trap_PC,
  output logic [31:0]        Trap_Tval,
  output logic               Stall,
  output logic [COUNT_W-1:0] Violation_Count,
  output logic               Missed
);

  trap_state_e state_q, state_d;
  logic        fault;
  logic        capture;
  logic        missed_set;
  logic [3:0]  cause_d;
  logic [31:0] tval_d;

  logic        trap_req_q;
  logic        stall_q;
  logic        missed_q;
  logic [3:0]  cause_q;
  logic [7:0]  pc_q;
  logic [31:0] tval_q;

  assign fault = Instr_Fault | Data_Fault;

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    missed_set = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLDOFF: begin
        if (fault) begin
          capture = 1'b1;
          state_d = ST_TRAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: begin
        // Faults here cannot be captured; ack still releases the trap.
        missed_set = fault;
        if (Trap_Ack) state_d = ST_HOLDOFF;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cause_d = fault_cause(Instr_Fault, Fault_Opcode);
    tval_d  = Instr_Fault ? {24'b0, Fault_PC} : Fault_Addr;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_IDLE;
      trap_req_q <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trap_req_q <= (state_d == ST_TRAP);
      stall_q    <= (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
    end else if (capture) begin
      cause_q <= cause_d;
      pc_q    <= Fault_PC;
      tval_q  <= tval_d;
    end
  end

  // Clear and set in the same cycle leaves Missed set.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      missed_q <= 1'b0;
    end else begin
      missed_q <= (missed_q & ~Log_Clear) | missed_set;
    end
  end

  pmp_sat_counter #(
    .WIDTH(COUNT_W)
  ) u_viol_cnt (
    .clk   (Clock),
    .rst_n (Reset_n),
    .inc   (fault),
    .clr   (Log_Clear),
    .count (Violation_Count)
  );

  assign Trap_Req   = trap_req_q;
  assign Stall      = stall_q;
  assign Missed     = missed_q;
  assign Trap_Cause = cause_q;
  assign Trap_PC    = pc_q;
  assign Trap_Tval  = tval_q;

endmodule
